// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmitter and the future receiver:
// parity encodings, data-length encodings, the transmit FSM state type and
// small helpers that turn the configuration fields into lengths and masks.
// No ports.

package uart_pkg;

    // Parity field encodings; 2'd3 also means "no parity".
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Data-length field encodings.
    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Number of data bits (5..8) for a data-length field value.
    function automatic logic [3:0] data_len(input logic [1:0] sel);
        return 4'd5 + {2'b00, sel};
    endfunction

    // Mask keeping only the configured number of low data bits.
    function automatic logic [7:0] data_mask(input logic [1:0] sel);
        logic [7:0] m;
        case (sel)
            DBITS_5: m = 8'h1F;
            DBITS_6: m = 8'h3F;
            DBITS_7: m = 8'h7F;
            DBITS_8: m = 8'hFF;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // A parity bit is sent only for the even and odd encodings.
    function automatic logic parity_en(input logic [1:0] par);
        return (par != PAR_NONE) && ((par == PAR_EVEN) || (par == PAR_ODD));
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Bit-period divider. The counter runs 0 .. div-1 and tick_o is high on the
// count div-1, so one tick arrives every div cycles. A divisor of 0 behaves
// like 1 (tick every cycle). clr_i restarts the period from count 0 on the
// next edge; the owning FSM drives it on every state entry.
//
// Ports:
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset
//   clr_i   in   restart the bit period
//   div_i   in   clock cycles per bit
//   tick_o  out  high during the last cycle of each bit period

module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] last_cnt;

    always_comb begin
        last_cnt = '0;
        if (div_i != '0) begin
            last_cnt = div_i - DIV_ONE;
        end
    end

    assign tick_o = (cnt_q == last_cnt);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_ONE;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
// Runtime-configurable UART transmitter: 5..8 data bits (LSB first),
// none/even/odd parity, 1 or 2 stop bits, bit period of baud_div_i cycles.
// A one-entry holding register in front of the shift register lets the next
// frame start on the edge right after the previous frame's last stop bit.
//
// Handshake: a word is transferred on a rising clk_i edge where
// valid_i && ready_o are both high; ready_o is high exactly when the holding
// register is empty, and data_i is not sampled at any other time.
//
// Configuration inputs are captured together with the word when the FSM
// loads a frame from the holding register and stay fixed for that frame.
//
// All outputs come from flops. tx_o, busy_o and done_o are registered from
// the current FSM state, so they trail the state register by one cycle; the
// whole frame (and the bit timing inside it) is shifted by that one cycle.
//
// Ports:
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   data_i       in   word to send; bits above the configured length ignored
//   valid_i      in   data_i is valid
//   ready_o      out  holding register empty
//   baud_div_i   in   clock cycles per bit (0 treated as 1)
//   data_bits_i  in   0..3 -> 5..8 data bits
//   parity_i     in   0 none, 1 even, 2 odd, 3 none
//   stop2_i      in   1 selects two stop bits
//   busy_o       out  a frame is on the line
//   done_o       out  one-cycle pulse on the last cycle of the last stop bit
//   tx_o         out  serial line, idle high

module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic [1:0]       data_bits_i,
    input  logic [1:0]       parity_i,
    input  logic             stop2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             tx_o
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    // FSM state
    tx_state_e state_q;
    tx_state_e state_d;

    // Holding register
    logic       hold_full_q;
    logic [7:0] hold_data_q;

    // Per-frame datapath and captured configuration
    logic [7:0]       shift_q;
    logic             par_bit_q;
    logic [3:0]       nbits_q;
    logic             par_en_q;
    logic             stop2_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_cnt_q;
    logic             stop_cnt_q;

    // Output registers
    logic tx_q;
    logic busy_q;
    logic done_q;

    // Control
    logic       accept;
    logic       load;
    logic       frame_end;
    logic       shift_en;
    logic       tx_d;
    logic       bit_tick;
    logic       baud_clr;
    logic [7:0] load_data;

    assign accept  = valid_i && !hold_full_q;
    assign ready_o = !hold_full_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign tx_o    = tx_q;

    // Word as it enters the shift register: upper bits beyond the
    // configured length are cleared so they never reach parity or the line.
    assign load_data = hold_data_q & data_mask(data_bits_i);

    // The period restarts on every state change; while idle it is held at
    // zero so the first START bit is a full period.
    assign baud_clr = (state_d != state_q) || (state_q == ST_IDLE);

    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (baud_clr),
        .div_i  (div_q),
        .tick_o (bit_tick)
    );

    // Next-state and control decode
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        frame_end = 1'b0;
        shift_en  = 1'b0;
        tx_d      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_tick) begin
                    shift_en = 1'b1;
                    if ({1'b0, bit_cnt_q} == (nbits_q - 4'd1)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                tx_d = par_bit_q;
                if (bit_tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                // With two stop bits the first tick only advances stop_cnt.
                if (bit_tick && (!stop2_q || stop_cnt_q)) begin
                    frame_end = 1'b1;
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, holding register, datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            nbits_q     <= '0;
            par_en_q    <= 1'b0;
            stop2_q     <= 1'b0;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;

            // A simultaneous fill and drain leaves the register full with
            // the incoming word.
            if (accept) begin
                hold_full_q <= 1'b1;
                hold_data_q <= data_i;
            end else if (load) begin
                hold_full_q <= 1'b0;
            end

            if (load) begin
                shift_q    <= load_data;
                par_bit_q  <= (parity_i == PAR_ODD) ? ~(^load_data) : (^load_data);
                nbits_q    <= data_len(data_bits_i);
                par_en_q   <= parity_en(parity_i);
                stop2_q    <= stop2_i;
                div_q      <= (baud_div_i == '0) ? DIV_ONE : baud_div_i;
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
            end else begin
                if (shift_en) begin
                    shift_q   <= shift_q >> 1;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if ((state_q == ST_STOP) && bit_tick) begin
                    stop_cnt_q <= 1'b1;
                end
            end

            tx_q   <= tx_d;
            busy_q <= (state_q != ST_IDLE);
            done_q <= frame_end;
        end
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Runtime-configurable UART transmitter, the parametrised successor of the fixed 8N1 transmitter. It serialises words of 5–8 data bits with optional even/odd parity and 1 or 2 stop bits, at a bit period set at run time. A one-entry holding register allows back-to-back frames with no idle gap. It sits between the register/FIFO side of the UART controller and the tx pad.

## Interface
- `DIV_W`, default 16: width of the baud divisor.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `data_i`, in, 8: word to send, LSB first; bits above the configured length are ignored.
- `valid_i`, in, 1: `data_i` is valid.
- `ready_o`, out, 1: holding register is empty; the word is taken when `valid_i && ready_o`.
- `baud_div_i`, in, DIV_W: clock cycles per bit; 0 is treated as 1.
- `data_bits_i`, in, 2: 0→5, 1→6, 2→7, 3→8 data bits.
- `parity_i`, in, 2: 0 none, 1 even, 2 odd, 3 none.
- `stop2_i`, in, 1: 0 gives one stop bit, 1 gives two.
- `busy_o`, out, 1: a frame is on the line (START through last STOP).
- `done_o`, out, 1: one-cycle pulse at the end of each frame's last stop bit.
- `tx_o`, out, 1: serial line, idle high.

## Operation
- Reset values:
  - `tx_o` = 1, `ready_o` = 1, `busy_o` = 0, `done_o` = 0.
  - Holding register empty, FSM in IDLE, all counters 0.
- Holding register (1 entry):
  - Filled on handshake; `ready_o` = !full.
  - Drained when the FSM loads a frame.
  - Fill and drain in the same cycle keeps it full with the new word.
- Configuration:
  - `baud_div_i`, `data_bits_i`, `parity_i` and `stop2_i` are sampled when a frame is loaded from the holding register and held for that frame.
  - Changes mid-frame take effect on the next frame only.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: `tx_o` = 1. When the holding register is full, load the shift register and config, then go to START.
  - START: `tx_o` = 0 for one bit period.
  - DATA: send `shift[0]`, shift right, for N bit periods (N = 5..8).
  - PARITY: entered only when parity is enabled. Bit = XOR of the N data bits for even, its inverse for odd.
  - STOP: `tx_o` = 1 for 1 or 2 bit periods. At the end, pulse `done_o`. If the holding register is full, load it and go straight to START; otherwise go to IDLE.
- Bit timing:
  - The divisor counter runs from 0 to `div-1`. `bit_tick` is asserted on the count `div-1`, and the counter clears on every state entry.
  - Each line bit lasts exactly `div` cycles.
- Parity is computed from the masked data (`data_i & mask(N)`) when the word is loaded.
- Reset asserted mid-frame:
  - `tx_o` returns to 1 on the next edge and the holding register is emptied.
  - No `done_o` pulse is produced.

## Timing
- Handshake at edge T with FSM in IDLE: the holding register fills at T and the FSM loads at T+1. `tx_o` goes low at edge T+2, so latency is 2 cycles.
- Frame length = `div × (1 + N + P + S)` cycles, where P ∈ {0,1} and S ∈ {1,2}.
- Back-to-back frames: the next START begins on the edge right after the last STOP bit of the previous frame, with zero idle cycles.
- `done_o` is high for exactly one cycle: the last cycle of the last stop bit.
- `busy_o` is high for exactly the frame length.
- `ready_o` rises on the cycle after a load drains the holding register. A second word is accepted during the current frame.
- All outputs are registered; `tx_o` has no glitches.

## Structure
- Shared package `uart_pkg`:
  - Parity encodings (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`).
  - FSM state enum.
  - Data-bits encoding constants.
- Sub-module `uart_baud_gen`:
  - Parameter `DIV_W`.
  - Inputs: `clk_i`, `rst_i`, `clr_i`, `div_i`.
  - Output: `tick_o`.
  - It is reused by the future receiver.
- The top level holds the holding register, the FSM, the shift register and the bit counters.

## Test plan
- 8N1, div=4, `data_i` = 0xA5 → `tx_o` low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. `done_o` pulses at cycle 40 after the START edge.
- 7E2, div=3, `data_i` = 0xC1 → 7 data bits 1,0,0,0,0,0,1, parity 0, two stop bits. Frame = 33 cycles; bit 7 of the input is ignored.
- 5O1, div=2, `data_i` = 0x07 → data bits 1,1,1,0,0, parity 0 (odd: three ones). Frame = 16 cycles.
- Two words 0x55 and 0xAA offered on consecutive cycles, 8N1, div=2:
  - Both are accepted; `ready_o` is low between them.
  - The second START immediately follows the first STOP, with no idle gap.
  - `busy_o` stays high for 40 cycles.
- div=0 → identical waveform to div=1. Changing `data_bits_i` mid-frame does not alter the current frame.
- `rst_i` asserted in DATA → next edge: `tx_o` = 1, `ready_o` = 1, `busy_o` = 0, no `done_o`. A new word then starts cleanly.
